// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the rule for which codes actually move data.
package barrel_shifter_pkg;

  localparam logic [2:0] MODE_ROR  = 3'd0;
  localparam logic [2:0] MODE_ROL  = 3'd1;
  localparam logic [2:0] MODE_LSR  = 3'd2;
  localparam logic [2:0] MODE_LSL  = 3'd3;
  localparam logic [2:0] MODE_ASR  = 3'd4;
  // Any code above MODE_ASR leaves the operand untouched; this is the canonical one.
  localparam logic [2:0] MODE_PASS = 3'd7;

  // True for codes that shift or rotate; pass-through codes ignore the amount.
  function automatic logic shifts_data(input logic [2:0] mode);
    return (mode <= MODE_ASR);
  endfunction

endpackage

// File: rtl/barrel_shifter_pipe_stage.sv
// One pipeline stage: conditionally shifts/rotates by a fixed SHIFT positions
// (selected by the matching amount bit) and registers the result together
// with the sideband needed by later stages.
module shifter_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1,
  localparam int AMT_W = $clog2(WIDTH),
  localparam int BIT   = $clog2(SHIFT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] up_data,
  input  logic [AMT_W-1:0] up_amt,
  input  logic [2:0]       up_mode,
  input  logic             up_sign,
  input  logic             up_vld,
  input  logic             dn_load,
  output logic [WIDTH-1:0] data_p,
  output logic [AMT_W-1:0] amt_p,
  output logic [2:0]       mode_p,
  output logic             sign_p,
  output logic             vld_p,
  output logic             load
);

  // Fixed-distance move; arithmetic fill uses the original operand sign so
  // that composing stages gives the same result as one wide shift.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [2:0]       m,
                                                input logic             s);
    case (m)
      MODE_ROR: return {d[SHIFT-1:0], d[WIDTH-1:SHIFT]};
      MODE_ROL: return {d[WIDTH-SHIFT-1:0], d[WIDTH-1:WIDTH-SHIFT]};
      MODE_LSR: return {{SHIFT{1'b0}}, d[WIDTH-1:SHIFT]};
      MODE_LSL: return {d[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
      MODE_ASR: return {{SHIFT{s}}, d[WIDTH-1:SHIFT]};
      default:  return d;
    endcase
  endfunction

  logic             en;
  logic [WIDTH-1:0] shifted;

  assign en      = up_amt[BIT] && shifts_data(up_mode);
  assign shifted = en ? shift_by(up_data, up_mode, up_sign) : up_data;

  // Stage accepts new contents when empty or when the next stage is taking ours.
  assign load = !vld_p || dn_load;

  // Occupancy flag: the only state cleared by reset; empty slots collapse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p <= 1'b0;
    else if (load) vld_p <= up_vld;
  end

  // Payload register, qualified by vld_p so it needs no reset.
  always_ff @(posedge clk) begin
    if (load && up_vld) begin
      data_p <= shifted;
      amt_p  <= up_amt;
      mode_p <= up_mode;
      sign_p <= up_sign;
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined multifunction barrel shifter with valid/ready flow control.
// Stage k handles amount bit k; the ready chain runs combinationally from
// out_ready_in back to in_ready_out so the pipe sustains one op per cycle.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [AMT_W-1:0] amt_in,
  input  logic [2:0]       mode_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  output logic [WIDTH-1:0] out_out,
  output logic             zero_out,
  output logic             out_valid_out,
  input  logic             out_ready_in
);

  // Index 0 is the input side, index AMT_W is the final register.
  logic [WIDTH-1:0] data_s [AMT_W+1];
  logic [AMT_W-1:0] amt_s  [AMT_W+1];
  logic [2:0]       mode_s [AMT_W+1];
  logic             sign_s [AMT_W+1];
  logic             vld_s  [AMT_W+1];
  logic             load_s [AMT_W+1];

  assign data_s[0]     = a_in;
  assign amt_s[0]      = amt_in;
  assign mode_s[0]     = mode_in;
  assign sign_s[0]     = a_in[WIDTH-1];
  assign vld_s[0]      = in_valid_in;
  assign load_s[AMT_W] = out_ready_in;
  assign in_ready_out  = load_s[0];

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    shifter_stage #(
      .WIDTH(WIDTH),
      .SHIFT(1 << k)
    ) u_stage (
      .clk    (clk_in),
      .rst    (reset_in),
      .up_data(data_s[k]),
      .up_amt (amt_s[k]),
      .up_mode(mode_s[k]),
      .up_sign(sign_s[k]),
      .up_vld (vld_s[k]),
      .dn_load(load_s[k+1]),
      .data_p (data_s[k+1]),
      .amt_p  (amt_s[k+1]),
      .mode_p (mode_s[k+1]),
      .sign_p (sign_s[k+1]),
      .vld_p  (vld_s[k+1]),
      .load   (load_s[k])
    );
  end

  // Final register: result is forced to zero whenever the slot is empty,
  // which also gives the cleared output during and after reset.
  assign out_valid_out = vld_s[AMT_W];
  assign out_out       = vld_s[AMT_W] ? data_s[AMT_W] : '0;
  assign zero_out      = vld_s[AMT_W] && (data_s[AMT_W] == '0);

  // Sideband of the last stage has no consumer.
  logic unused_tail;
  assign unused_tail = ^{amt_s[AMT_W], mode_s[AMT_W], sign_s[AMT_W]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;

  logic clk, rst;

  logic [7:0]  a8, o8;
  logic [2:0]  amt8, mode8;
  logic        iv8, ir8, ov8, or8, z8;

  logic [31:0] a32, o32;
  logic [4:0]  amt32;
  logic [2:0]  mode32;
  logic        iv32, ir32, ov32, or32, z32;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] q8[$];
  logic [63:0] q32[$];

  barrel_shifter_pipe #(.WIDTH(8)) dut8 (
    .clk_in(clk), .reset_in(rst), .a_in(a8), .amt_in(amt8), .mode_in(mode8),
    .in_valid_in(iv8), .in_ready_out(ir8), .out_out(o8), .zero_out(z8),
    .out_valid_out(ov8), .out_ready_in(or8));

  barrel_shifter_pipe #(.WIDTH(32)) dut32 (
    .clk_in(clk), .reset_in(rst), .a_in(a32), .amt_in(amt32), .mode_in(mode32),
    .in_valid_in(iv32), .in_ready_out(ir32), .out_out(o32), .zero_out(z32),
    .out_valid_out(ov32), .out_ready_in(or32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: whole-amount operation expressed with plain arithmetic on w bits.
  function automatic logic [63:0] model(input logic [63:0] a, input int amt,
                                        input int mode, input int w);
    logic [63:0] mask, x, r;
    mask = (64'd1 << w) - 64'd1;
    x = a & mask;
    case (mode)
      0: r = ((x >> amt) | (x << (w - amt))) & mask;
      1: r = ((x << amt) | (x >> (w - amt))) & mask;
      2: r = x >> amt;
      3: r = (x << amt) & mask;
      4: r = x[w-1] ? ((x >> amt) | (mask & ~(mask >> amt))) : (x >> amt);
      default: r = x;
    endcase
    return r;
  endfunction

  // Scoreboards: push on input transfer, compare every valid cycle, pop on output transfer.
  always @(negedge clk) begin
    if (rst) q8.delete();
    else begin
      if (ov8) begin
        if (q8.size() == 0) chk("unexpected_out8", 64'(ov8), 64'd0);
        else begin
          chk("out8", 64'(o8), q8[0]);
          chk("zero8", 64'(z8), 64'(q8[0] == 64'd0));
          if (or8) void'(q8.pop_front());
        end
      end
      if (iv8 && ir8) q8.push_back(model(64'(a8), int'(amt8), int'(mode8), 8));
    end
  end

  always @(negedge clk) begin
    if (rst) q32.delete();
    else begin
      if (ov32) begin
        if (q32.size() == 0) chk("unexpected_out32", 64'(ov32), 64'd0);
        else begin
          chk("out32", 64'(o32), q32[0]);
          chk("zero32", 64'(z32), 64'(q32[0] == 64'd0));
          if (or32) void'(q32.pop_front());
        end
      end
      if (iv32 && ir32) q32.push_back(model(64'(a32), int'(amt32), int'(mode32), 32));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov8(input int lim);
    int n = 0;
    while (!ov8 && n < lim) begin tick(); n++; end
    if (!ov8) chk("timeout8", 64'(ov8), 64'd1);
  endtask

  task automatic wait_ov32(input int lim);
    int n = 0;
    while (!ov32 && n < lim) begin tick(); n++; end
    if (!ov32) chk("timeout32", 64'(ov32), 64'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [2:0] amt, input logic [2:0] mode,
                     input logic [7:0] exp, input logic expz, input string nm);
    a8 = a; amt8 = amt; mode8 = mode; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    wait_ov8(10);
    chk(nm, 64'(o8), 64'(exp));
    chk({nm, "_zero"}, 64'(z8), 64'(expz));
    tick();
  endtask

  task automatic op32(input logic [31:0] a, input logic [4:0] amt, input logic [2:0] mode,
                      input logic [31:0] exp, input string nm);
    a32 = a; amt32 = amt; mode32 = mode; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    wait_ov32(10);
    chk(nm, 64'(o32), 64'(exp));
    tick();
  endtask

  logic [7:0] bp_a [5] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h11};

  initial begin
    int idx, acc_n, sent;
    logic acc, pend;
    rst = 1'b1;
    iv8 = 0; a8 = 0; amt8 = 0; mode8 = 0; or8 = 1;
    iv32 = 0; a32 = 0; amt32 = 0; mode32 = 0; or32 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid8", 64'(ov8), 64'd0);
    chk("rst_out8", 64'(o8), 64'd0);
    chk("rst_zero8", 64'(z8), 64'd0);
    chk("rst_valid32", 64'(ov32), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready8", 64'(ir8), 64'd1);
    chk("ready32", 64'(ir32), 64'd1);
    tick();

    // Back-to-back rotate right then rotate left; exact latency AMT_W-1 edges.
    a8 = 8'hF0; amt8 = 3'd2; mode8 = 3'd0; iv8 = 1'b1;
    tick();
    mode8 = 3'd1;
    tick();
    iv8 = 1'b0;
    tick();
    chk("ror_vld", 64'(ov8), 64'd1);
    chk("ror", 64'(o8), 64'h3C);
    tick();
    chk("rol_vld", 64'(ov8), 64'd1);
    chk("rol", 64'(o8), 64'hC3);
    tick();

    op8(8'h90, 3'd3, 3'd4, 8'hF2, 1'b0, "asr");
    op8(8'h90, 3'd3, 3'd2, 8'h12, 1'b0, "lsr");
    op8(8'h80, 3'd1, 3'd3, 8'h00, 1'b1, "lsl_zero");
    op8(8'hA5, 3'd5, 3'd6, 8'hA5, 1'b0, "pass6");
    for (int m = 0; m < 8; m++) op8(8'h5B, 3'd0, 3'(m), 8'h5B, 1'b0, "amt0");

    // Backpressure: five rotate-left-by-1 ops against a stalled sink.
    or8 = 1'b0; idx = 0; acc_n = 0;
    for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
      if (cyc == 6) begin
        chk("bp_accepted", 64'(acc_n), 64'd3);
        chk("bp_ready", 64'(ir8), 64'd0);
        chk("bp_valid", 64'(ov8), 64'd1);
        chk("bp_hold", 64'(o8), 64'h03);
        or8 = 1'b1;
      end
      a8 = bp_a[idx]; amt8 = 3'd1; mode8 = 3'd1; iv8 = 1'b1;
      @(negedge clk);
      acc = iv8 && ir8;
      @(posedge clk);
      #1;
      if (acc) begin idx++; acc_n++; end
    end
    iv8 = 1'b0;
    chk("bp_total", 64'(idx), 64'd5);
    repeat (6) tick();
    chk("bp_drained", 64'(q8.size()), 64'd0);

    // Reset with two ops in flight, the first already presented.
    a8 = 8'hF0; amt8 = 3'd1; mode8 = 3'd0; iv8 = 1'b1;
    tick();
    a8 = 8'h0F;
    tick();
    iv8 = 1'b0;
    tick();
    chk("pre_rst_valid", 64'(ov8), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(ov8), 64'd0);
    chk("midrst_out", 64'(o8), 64'd0);
    chk("midrst_zero", 64'(z8), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(ir8), 64'd1);
    repeat (6) tick();
    chk("post_rst_valid", 64'(ov8), 64'd0);

    // 32-bit corners.
    op32(32'h80000000, 5'd31, 3'd4, 32'hFFFFFFFF, "asr31");
    op32(32'h00000003, 5'd31, 3'd1, 32'h80000001, "rol31");

    // 32-bit random traffic with toggled valid/ready.
    sent = 0; pend = 1'b0;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      if (!pend && $urandom_range(0, 9) < 7) begin
        a32 = $urandom;
        amt32 = 5'($urandom_range(0, 31));
        mode32 = 3'($urandom_range(0, 7));
        pend = 1'b1;
      end
      iv32 = pend;
      or32 = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = iv32 && ir32;
      @(posedge clk);
      #1;
      if (acc) begin pend = 1'b0; sent++; end
    end
    iv32 = 1'b0; or32 = 1'b1;
    chk("rand_sent", 64'(sent), 64'd1000);
    repeat (10) tick();
    chk("rand_drained", 64'(q32.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
